// File: rtl/nn_host_ctrl.sv
// rtl/nn_host_ctrl.sv - host-side sequencer that streams features into an NN core and reads scores back
module nn_host_ctrl #(
    parameter int NUM_INPUTS  = 8,
    parameter int NUM_OUTPUTS = 5,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int TIMEOUT     = 65535
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic signed [DATA_WIDTH-1:0] m_data,
    output logic [7:0]                   m_index,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last,
    output logic [7:0]                   m_class,
    output logic [ADDR_WIDTH-1:0]        nn_addr,
    output logic signed [DATA_WIDTH-1:0] nn_data,
    output logic                         nn_we,
    output logic                         nn_valid,
    output logic                         nn_start,
    input  logic                         nn_done,
    input  logic signed [DATA_WIDTH-1:0] nn_rdata,
    input  logic                         nn_rvalid,
    input  logic [7:0]                   nn_class,
    output logic                         busy,
    output logic                         err_timeout
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [7:0]        LAST_IN   = 8'(NUM_INPUTS - 1);
    localparam logic [7:0]        LAST_OUT  = 8'(NUM_OUTPUTS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        LOAD      = 3'd0,
        START     = 3'd1,
        WAIT_DONE = 3'd2,
        RD_REQ    = 3'd3,
        RD_WAIT   = 3'd4,
        OUT       = 3'd5
    } state_t;

    state_t                  state, state_next;
    logic [7:0]              load_cnt, load_cnt_next;
    logic [7:0]              rd_cnt, rd_cnt_next;
    logic [WAIT_W-1:0]       wait_cnt, wait_cnt_next;
    logic [7:0]              class_q, class_next;
    logic [DATA_WIDTH-1:0]   score_q, score_next;
    logic                    err_q, err_next;
    logic [7:0]              cmd_addr;

    // Counters are 8 bits wide; the core bus may be wider or narrower.
    assign nn_addr     = ADDR_WIDTH'(cmd_addr);
    assign m_class     = class_q;
    assign err_timeout = err_q;
    assign busy        = reset && !(state == LOAD && load_cnt == 8'd0);

    // Register all sequencer state; reset abandons any partial inference.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= LOAD;
            load_cnt <= 8'd0;
            rd_cnt   <= 8'd0;
            wait_cnt <= '0;
            class_q  <= 8'd0;
            score_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            load_cnt <= load_cnt_next;
            rd_cnt   <= rd_cnt_next;
            wait_cnt <= wait_cnt_next;
            class_q  <= class_next;
            score_q  <= score_next;
            err_q    <= err_next;
        end
    end

    // Next-state and command/stream outputs; everything idles to zero by default.
    always_comb begin
        state_next    = state;
        load_cnt_next = load_cnt;
        rd_cnt_next   = rd_cnt;
        wait_cnt_next = wait_cnt;
        class_next    = class_q;
        score_next    = score_q;
        err_next      = err_q;
        s_ready       = 1'b0;
        nn_valid      = 1'b0;
        nn_we         = 1'b0;
        nn_start      = 1'b0;
        cmd_addr      = 8'd0;
        nn_data       = '0;
        m_valid       = 1'b0;
        m_data        = '0;
        m_index       = 8'd0;
        m_last        = 1'b0;

        case (state)
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    nn_valid = 1'b1;
                    nn_we    = 1'b1;
                    cmd_addr = load_cnt;
                    nn_data  = s_data;
                    if (load_cnt == LAST_IN) begin
                        load_cnt_next = 8'd0;
                        state_next    = START;
                    end else begin
                        load_cnt_next = load_cnt + 8'd1;
                    end
                end
            end
            START: begin
                nn_start      = 1'b1;
                wait_cnt_next = '0;
                state_next    = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (nn_done) begin
                    class_next    = nn_class;
                    rd_cnt_next   = 8'd0;
                    wait_cnt_next = '0;
                    state_next    = RD_REQ;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_next      = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = LOAD;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            RD_REQ: begin
                // Each read gets its own full wait budget.
                nn_valid      = 1'b1;
                cmd_addr      = rd_cnt;
                wait_cnt_next = '0;
                state_next    = RD_WAIT;
            end
            RD_WAIT: begin
                if (nn_rvalid) begin
                    score_next    = nn_rdata;
                    wait_cnt_next = '0;
                    state_next    = OUT;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_next      = 1'b1;
                    wait_cnt_next = '0;
                    rd_cnt_next   = 8'd0;
                    state_next    = LOAD;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            OUT: begin
                m_valid = 1'b1;
                m_data  = score_q;
                m_index = rd_cnt;
                m_last  = (rd_cnt == LAST_OUT);
                if (m_ready) begin
                    if (rd_cnt == LAST_OUT) begin
                        rd_cnt_next = 8'd0;
                        state_next  = LOAD;
                    end else begin
                        rd_cnt_next = rd_cnt + 8'd1;
                        state_next  = RD_REQ;
                    end
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase

        // While reset is held nothing may reach the core or the score stream.
        if (!reset) begin
            s_ready  = 1'b1;
            nn_valid = 1'b0;
            nn_we    = 1'b0;
            nn_start = 1'b0;
            cmd_addr = 8'd0;
            nn_data  = '0;
            m_valid  = 1'b0;
            m_data   = '0;
            m_index  = 8'd0;
            m_last   = 1'b0;
        end
    end

endmodule

// File: doc/nn_host_ctrl.md
NN_HOST_CTRL -- requirements
Module: nn_host_ctrl

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 8: feature beats per inference, 1..255.
REQ-002 SHALL have parameter NUM_OUTPUTS, default 5: output-layer neurons read back, 1..255.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: width of features and scores, signed.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8: width of the core address bus.
REQ-005 SHALL have parameter TIMEOUT, default 65535: maximum wait cycles in WAIT_DONE or RD_WAIT.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-low (0 = reset).
REQ-008 SHALL have port s_data, input, DATA_WIDTH: feature value.
REQ-009 SHALL have ports s_valid (input, 1) and s_ready (output, 1): feature handshake.
REQ-010 SHALL have port m_data, output, DATA_WIDTH: score.
REQ-011 SHALL have port m_index, output, 8: neuron index of m_data.
REQ-012 SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_last (output, 1): score handshake; m_last marks the final score.
REQ-013 SHALL have port m_class, output, 8: argmax class captured from the core.
REQ-014 SHALL have ports nn_addr (output, ADDR_WIDTH), nn_data (output, DATA_WIDTH), nn_we (output, 1), nn_valid (output, 1) and nn_start (output, 1): core command side.
REQ-015 SHALL have ports nn_done (input, 1), nn_rdata (input, DATA_WIDTH), nn_rvalid (input, 1) and nn_class (input, 8): core response side.
REQ-016 SHALL have ports busy (output, 1) and err_timeout (output, 1, sticky).

Function
REQ-017 SHALL implement FSM states LOAD, START, WAIT_DONE, RD_REQ, RD_WAIT, OUT.
REQ-018 In LOAD: s_ready=1; each s_valid&s_ready beat drives, the same cycle, nn_valid=1, nn_we=1, nn_addr=load_cnt, nn_data=s_data; load_cnt then increments.
REQ-019 LOAD->START on the beat where load_cnt==NUM_INPUTS-1; no beat accepted outside LOAD.
REQ-020 START: nn_start=1 for exactly one cycle, then ->WAIT_DONE; wait counter cleared.
REQ-021 WAIT_DONE: on nn_done=1, m_class<=nn_class and rd_cnt<=0, then ->RD_REQ; nn_done is honoured only in this state.
REQ-022 RD_REQ: nn_valid=1, nn_we=0, nn_addr=rd_cnt for one cycle, then ->RD_WAIT; at most one read outstanding.
REQ-023 RD_WAIT: on nn_rvalid=1, capture nn_rdata into output register, then ->OUT.
REQ-024 OUT: m_valid=1, m_data=captured score, m_index=rd_cnt, m_last=(rd_cnt==NUM_OUTPUTS-1); m_data/m_index/m_last held stable while m_valid&!m_ready.
REQ-025 OUT handshake: if m_last ->LOAD, else rd_cnt++ and ->RD_REQ; minimum per-score latency 3 cycles.
REQ-026 m_class SHALL hold its captured value until the next nn_done capture.
REQ-027 Timeout: counter increments each cycle in WAIT_DONE/RD_WAIT; reaching TIMEOUT sets err_timeout=1, drops the inference (no m_valid) and ->LOAD.
REQ-028 err_timeout SHALL clear only on reset.
REQ-029 busy=1 in every state except LOAD with load_cnt==0.
REQ-030 In any cycle not listed above, nn_valid, nn_we and nn_start SHALL be 0, with nn_addr and nn_data driven 0.
REQ-031 Counters SHALL be width-safe: load_cnt and rd_cnt are 8 bits; nn_addr is zero-extended or truncated to ADDR_WIDTH.

Reset
REQ-032 On reset=0 at a clock edge, from any state including mid-load or mid-readout: state=LOAD, load_cnt=rd_cnt=0, wait counter=0, err_timeout=0, m_class=0, captured score=0.
REQ-033 During and after reset, all outputs SHALL be 0 except s_ready=1 (LOAD); the partial inference is discarded without nn_start.

Verification
REQ-034 With default parameters, stream 8 features 1..8 with s_valid held high -> nn_addr 0..7 with nn_we=1 on consecutive cycles, then one nn_start pulse.
REQ-035 Core model asserts nn_done with nn_class=3, returning rdata=10*addr one cycle after each read, with m_ready=1 -> m_index 0..4, m_data 0,10,20,30,40, m_last only on index 4, m_class=3.
REQ-036 Hold m_ready=0 for 5 cycles on index 2 -> m_valid and m_data=20 stable, no nn_valid read issued until the handshake.
REQ-037 With TIMEOUT=16, never assert nn_done -> err_timeout=1 16 cycles after WAIT_DONE entry, return to LOAD with s_ready=1, no m_valid.
REQ-038 Apply reset=0 after 4 of 8 features -> next 8 features load from nn_addr 0 and err_timeout=0.
REQ-039 Pulse nn_done while in LOAD -> ignored: no readout starts and m_class is unchanged.
